// File: rtl/bldc_pkg.sv
// Shared Hall/commutation tables for the BLDC emulator and its controller.
// Phase indices select A/B/C (AA/BB/CC on the low side) within 3-bit drive vectors.
package bldc_pkg;

    typedef logic [2:0] hall_idx_t;

    localparam logic [1:0] PH_A = 2'd0;
    localparam logic [1:0] PH_B = 2'd1;
    localparam logic [1:0] PH_C = 2'd2;

    localparam hall_idx_t IDX_LAST = 3'd5;

    // {H1,H2,H3} per rotor index, forward order
    localparam logic [2:0] HALL_SEQ [6] = '{3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110};

    // Forward torque pair: FWD_HI high-side on, FWD_LO low-side on
    localparam logic [1:0] FWD_HI [6] = '{PH_A, PH_A, PH_B, PH_B, PH_C, PH_C};
    localparam logic [1:0] FWD_LO [6] = '{PH_B, PH_C, PH_C, PH_A, PH_A, PH_B};

    function automatic hall_idx_t idx_step(input hall_idx_t idx, input logic rev);
        hall_idx_t nxt;
        if (!rev) begin
            nxt = (idx >= IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            nxt = (idx == 3'd0 || idx > IDX_LAST) ? IDX_LAST : idx - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bldc_gate_classifier.sv
// Combinational classification of the six gate drives against the current rotor index.
// Outputs are mutually exclusive: off, fwd, rev, shoot, illegal.
module bldc_gate_classifier
    import bldc_pkg::*;
(
    input  logic      a_i,
    input  logic      aa_i,
    input  logic      b_i,
    input  logic      bb_i,
    input  logic      c_i,
    input  logic      cc_i,
    input  hall_idx_t idx_i,
    output logic      off_o,
    output logic      fwd_o,
    output logic      rev_o,
    output logic      shoot_o,
    output logic      illegal_o
);

    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] pair_hi;
    logic [2:0] pair_lo;
    logic       idx_ok;

    always_comb begin
        hi      = {c_i, b_i, a_i};
        lo      = {cc_i, bb_i, aa_i};
        idx_ok  = (idx_i <= IDX_LAST);
        pair_hi = 3'b000;
        pair_lo = 3'b000;
        if (idx_ok) begin
            pair_hi = 3'b001 << FWD_HI[idx_i];
            pair_lo = 3'b001 << FWD_LO[idx_i];
        end

        off_o     = (hi == 3'b000) && (lo == 3'b000);
        shoot_o   = |(hi & lo);
        fwd_o     = idx_ok && (hi == pair_hi) && (lo == pair_lo);
        // Reverse torque is the forward pair with high and low sides swapped
        rev_o     = idx_ok && (hi == pair_lo) && (lo == pair_hi);
        illegal_o = !off_o && !shoot_o && !fwd_o && !rev_o;
    end

endmodule

// File: rtl/bldc_hall_emulator.sv
// BLDC rotor/Hall model: measures drive duty per window and advances the Hall index at that rate.
// Flags shoot-through (sticky, freezes the rotor) and illegal commutation (sticky, informational).
module bldc_hall_emulator
    import bldc_pkg::*;
#(
    parameter int WIN_LOG2    = 4,
    parameter int ACC_W       = 12,
    parameter int STEP_THRESH = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                A,
    input  logic                AA,
    input  logic                B,
    input  logic                BB,
    input  logic                C,
    input  logic                CC,
    output logic                H1,
    output logic                H2,
    output logic                H3,
    output logic [WIN_LOG2:0]   SPEED,
    output logic                DIR,
    output logic                FAULT,
    output logic                ILLEGAL
);

    localparam logic [ACC_W:0] THRESH = (ACC_W+1)'(STEP_THRESH);

    logic off, fwd, rev, shoot, illegal, active, wrap;

    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_LOG2:0]   on_cnt_q, on_cnt_d;
    logic [WIN_LOG2:0]   speed_q, speed_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W:0]      sum;
    hall_idx_t           idx_q, idx_d;
    logic [2:0]          hall_q, hall_d;
    logic                dir_q, dir_d;
    logic                fault_q, fault_d;
    logic                illegal_q, illegal_d;

    bldc_gate_classifier u_classifier (
        .a_i       (A),
        .aa_i      (AA),
        .b_i       (B),
        .bb_i      (BB),
        .c_i       (C),
        .cc_i      (CC),
        .idx_i     (idx_q),
        .off_o     (off),
        .fwd_o     (fwd),
        .rev_o     (rev),
        .shoot_o   (shoot),
        .illegal_o (illegal)
    );

    always_comb begin
        active    = !off && !shoot && !illegal;
        wrap      = &win_cnt_q;
        win_cnt_d = win_cnt_q + WIN_LOG2'(1);
        on_cnt_d  = on_cnt_q + {{WIN_LOG2{1'b0}}, active};
        speed_d   = speed_q;
        if (wrap) begin
            speed_d  = on_cnt_d;
            on_cnt_d = '0;
        end

        dir_d     = rev ? 1'b1 : (fwd ? 1'b0 : dir_q);
        fault_d   = fault_q | shoot;
        illegal_d = illegal_q | illegal;

        // Motion uses the pre-wrap SPEED; a zero SPEED leaves acc unchanged naturally
        sum   = {1'b0, acc_q} + {{(ACC_W-WIN_LOG2){1'b0}}, speed_q};
        acc_d = acc_q;
        idx_d = idx_q;
        if (!fault_q) begin
            if (sum >= THRESH) begin
                acc_d = ACC_W'(sum - THRESH);
                idx_d = idx_step(idx_q, dir_q);
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        hall_d = 3'b100;
        if (idx_d <= IDX_LAST) begin
            hall_d = HALL_SEQ[idx_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            win_cnt_q <= '0;
            on_cnt_q  <= '0;
            speed_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            hall_q    <= 3'b100;
            dir_q     <= 1'b0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            on_cnt_q  <= on_cnt_d;
            speed_q   <= speed_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            hall_q    <= hall_d;
            dir_q     <= dir_d;
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
        end
    end

    assign {H1, H2, H3} = hall_q;
    assign SPEED        = speed_q;
    assign DIR          = dir_q;
    assign FAULT        = fault_q;
    assign ILLEGAL      = illegal_q;

endmodule

// File: tb/tb_bldc_hall_emulator.sv
// Directed bench for bldc_hall_emulator: reset, fwd/rev tracking, duty gating, shoot-through, illegal.
module tb_bldc_hall_emulator;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic A = 1'b0, AA = 1'b0, B = 1'b0, BB = 1'b0, C = 1'b0, CC = 1'b0;
    logic H1, H2, H3, DIR, FAULT, ILLEGAL;
    logic [4:0] SPEED;

    int nvec = 0;
    int nmis = 0;
    int cur;

    // {A,AA,B,BB,C,CC} for the forward and reverse torque pair at each index
    logic [5:0] FWDV [6] = '{6'b100100, 6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110};
    logic [5:0] REVV [6] = '{6'b011000, 6'b010010, 6'b000110, 6'b100100, 6'b100001, 6'b001001};
    logic [2:0] HALL [6] = '{3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110};

    bldc_hall_emulator #(.WIN_LOG2(4), .ACC_W(12), .STEP_THRESH(64)) dut (
        .CLK(CLK), .RST(RST),
        .A(A), .AA(AA), .B(B), .BB(BB), .C(C), .CC(CC),
        .H1(H1), .H2(H2), .H3(H3),
        .SPEED(SPEED), .DIR(DIR), .FAULT(FAULT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_drv(input logic [5:0] v);
        {A, AA, B, BB, C, CC} = v;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_drv(6'b0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // 1. reset state
        do_reset();
        check("rst_hall",    {13'b0, H1, H2, H3}, 16'b100);
        check("rst_speed",   {11'b0, SPEED}, 16'd0);
        check("rst_dir",     {15'b0, DIR}, 16'd0);
        check("rst_fault",   {15'b0, FAULT}, 16'd0);
        check("rst_illegal", {15'b0, ILLEGAL}, 16'd0);

        // 2. continuous forward drive: SPEED=16 at clk16, step every 4 clocks from clk20
        cur = 0;
        for (int k = 1; k <= 44; k++) begin
            set_drv(FWDV[cur]);
            tick();
            if (k >= 20 && (k - 20) % 4 == 0) cur = (cur + 1) % 6;
            if (k == 15) check("fwd_speed_pre", {11'b0, SPEED}, 16'd0);
            if (k == 16) check("fwd_speed",     {11'b0, SPEED}, 16'd16);
            if (k == 19) check("fwd_hall_pre",  {13'b0, H1, H2, H3}, 16'b100);
            if (k >= 20 && (k - 20) % 4 == 0)
                check("fwd_hall_step", {13'b0, H1, H2, H3}, {13'b0, HALL[cur]});
        end
        check("fwd_dir", {15'b0, DIR}, 16'd0);

        // 3. forward drive gated 8 on / 8 off: SPEED=8, step every 8 clocks from clk24
        do_reset();
        cur = 0;
        for (int k = 1; k <= 48; k++) begin
            set_drv((((k - 1) % 16) < 8) ? FWDV[cur] : 6'b0);
            tick();
            if (k >= 24 && (k - 24) % 8 == 0) cur = (cur + 1) % 6;
            if (k == 16 || k == 32) check("gate_speed", {11'b0, SPEED}, 16'd8);
            if (k == 23) check("gate_hall_pre", {13'b0, H1, H2, H3}, 16'b100);
            if (k >= 24 && (k - 24) % 8 == 0)
                check("gate_hall_step", {13'b0, H1, H2, H3}, {13'b0, HALL[cur]});
        end

        // 4. continuous reverse drive: DIR=1, first step wraps index 0 -> 5
        do_reset();
        cur = 0;
        for (int k = 1; k <= 28; k++) begin
            set_drv(REVV[cur]);
            tick();
            if (k >= 20 && (k - 20) % 4 == 0) cur = (cur == 0) ? 5 : cur - 1;
            if (k == 1)  check("rev_dir",   {15'b0, DIR}, 16'd1);
            if (k == 16) check("rev_speed", {11'b0, SPEED}, 16'd16);
            if (k >= 20 && (k - 20) % 4 == 0)
                check("rev_hall_step", {13'b0, H1, H2, H3}, {13'b0, HALL[cur]});
        end

        // 5. one shoot-through cycle freezes the rotor until reset
        set_drv(6'b110000);
        tick();
        check("shoot_fault",   {15'b0, FAULT}, 16'd1);
        check("shoot_illegal", {15'b0, ILLEGAL}, 16'd0);
        for (int k = 1; k <= 50; k++) begin
            set_drv(REVV[3]);
            tick();
        end
        check("shoot_hall_frozen", {13'b0, H1, H2, H3}, 16'b011);
        check("shoot_fault_hold",  {15'b0, FAULT}, 16'd1);
        RST = 1'b1;
        tick();
        check("shoot_rst_fault", {15'b0, FAULT}, 16'd0);
        check("shoot_rst_hall",  {13'b0, H1, H2, H3}, 16'b100);
        check("shoot_rst_speed", {11'b0, SPEED}, 16'd0);

        // 6. illegal A+C- at idx0, motion continues, then drives off for a full window
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            if (k == 17)     set_drv(6'b100001);
            else if (k <= 20) set_drv(6'b100100);
            else             set_drv(6'b0);
            tick();
            if (k == 16) check("ill_pre",      {15'b0, ILLEGAL}, 16'd0);
            if (k == 17) check("ill_set",      {15'b0, ILLEGAL}, 16'd1);
            if (k == 17) check("ill_no_fault", {15'b0, FAULT}, 16'd0);
            if (k == 20) check("ill_hall_20",  {13'b0, H1, H2, H3}, 16'b101);
            if (k == 32) check("ill_speed_32", {11'b0, SPEED}, 16'd3);
            if (k == 32) check("ill_hall_32",  {13'b0, H1, H2, H3}, 16'b010);
            if (k == 48) check("ill_speed_48", {11'b0, SPEED}, 16'd0);
            if (k == 48) check("ill_hall_48",  {13'b0, H1, H2, H3}, 16'b010);
        end
        for (int k = 1; k <= 20; k++) tick();
        check("idle_hall_hold", {13'b0, H1, H2, H3}, 16'b010);
        check("idle_illegal",   {15'b0, ILLEGAL}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
